// File: rtl/rom_rd_arbiter.sv
// rtl/rom_rd_arbiter.sv - round-robin read arbiter sharing one synchronous ROM among NREQ requesters
// Optional per-requester grant counters enabled by defining ROM_RD_ARB_STATS_EN.
module rom_rd_arbiter #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int NREQ  = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NREQ-1:0]             req,
  input  logic [NREQ*$clog2(DEPTH)-1:0] req_addr,
  output logic [NREQ-1:0]             gnt,
  output logic [$clog2(DEPTH)-1:0]    rom_addr,
  output logic                        rom_en,
  input  logic [WIDTH-1:0]            rom_data,
  output logic [NREQ-1:0]             rsp_valid,
  output logic [WIDTH-1:0]            rsp_data,
  output logic [NREQ*16-1:0]          grant_cnt
);

  localparam int DEPTH_LOG = $clog2(DEPTH);
  localparam int PTR_W     = $clog2(NREQ);

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] gnt_idx;
  logic [NREQ-1:0]  tag;
  logic             found;
  int               idx;

  // Search starts one past the last winner so every active requester gets its turn.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    if (!rst) begin
      for (int k = 1; k <= NREQ; k++) begin
        idx = (int'(ptr) + k) % NREQ;
        if (!found && req[idx]) begin
          found        = 1'b1;
          gnt[idx]     = 1'b1;
          gnt_idx      = idx[PTR_W-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= PTR_W'(NREQ - 1);
      rom_addr  <= '0;
      rom_en    <= 1'b0;
      tag       <= '0;
      rsp_valid <= '0;
    end else begin
      if (found) begin
        ptr      <= gnt_idx;
        rom_addr <= req_addr[gnt_idx*DEPTH_LOG +: DEPTH_LOG];
      end
      rom_en    <= found;
      tag       <= gnt;
      rsp_valid <= tag;
    end
  end

  assign rsp_data = rom_data;

`ifdef ROM_RD_ARB_STATS_EN
  logic [15:0] cnt [NREQ];

  always_ff @(posedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (rst)
        cnt[i] <= '0;
      else if (gnt[i] && cnt[i] != 16'hFFFF)
        cnt[i] <= cnt[i] + 16'd1;
    end
  end

  for (genvar g = 0; g < NREQ; g++) begin : g_cnt
    assign grant_cnt[g*16 +: 16] = cnt[g];
  end
`else
  assign grant_cnt = '0;
`endif

endmodule
